// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared widths, ALU opcode / result-class encodings and the
//               divider FSM state encodings for the EX mul/div stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

  localparam int REG_W     = 32;
  localparam int ALUOP_W   = 8;
  localparam int ALUSEL_W  = 3;
  localparam int REGADDR_W = 5;

  // ALU operations
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP    = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP    = 8'h24;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP     = 8'h25;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP    = 8'h26;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP    = 8'h7C;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP    = 8'h02;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP    = 8'h03;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP    = 8'h20;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP    = 8'h22;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP    = 8'h2A;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP   = 8'h2B;
  localparam logic [ALUOP_W-1:0] EXE_MUL_OP    = 8'h18;
  localparam logic [ALUOP_W-1:0] EXE_MULH_OP   = 8'h19;
  localparam logic [ALUOP_W-1:0] EXE_MULHSU_OP = 8'h1A;
  localparam logic [ALUOP_W-1:0] EXE_MULHU_OP  = 8'h1B;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP    = 8'h1C;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP   = 8'h1D;
  localparam logic [ALUOP_W-1:0] EXE_REM_OP    = 8'h1E;
  localparam logic [ALUOP_W-1:0] EXE_REMU_OP   = 8'h1F;

  // Result classes
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP    = 3'd0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC  = 3'd1;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT  = 3'd2;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH  = 3'd3;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MULDIV = 3'd4;

  // Divider FSM
  localparam int                DIV_ST_W = 2;
  localparam logic [DIV_ST_W-1:0] DIV_IDLE = 2'd0;
  localparam logic [DIV_ST_W-1:0] DIV_BUSY = 2'd1;
  localparam logic [DIV_ST_W-1:0] DIV_DONE = 2'd2;

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative restoring divider, one quotient bit per cycle.
//               Works on operand magnitudes and sign-corrects at the output.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = REG_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sgn,
  input  logic            hold,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [5:0] DIV_LAST = 6'(XLEN - 1);

  logic [DIV_ST_W-1:0] r_state;
  logic [DIV_ST_W-1:0] w_state_nxt;
  logic [5:0]          r_cnt;
  logic [XLEN-1:0]     r_quot;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_dvsr;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic [XLEN:0]       w_shift;
  logic [XLEN:0]       w_diff;

  assign w_abs_a = (sgn && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
  assign w_abs_b = (sgn && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;

  // Partial remainder shifted left with the next dividend bit; the borrow of
  // the trial subtraction decides the quotient bit.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DIV_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: 32 BUSY steps, DONE held while the pipeline is stalled
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (start)              w_state_nxt = DIV_BUSY;
      DIV_BUSY: if (r_cnt == DIV_LAST)  w_state_nxt = DIV_DONE;
      DIV_DONE: if (!hold)              w_state_nxt = DIV_IDLE;
      default:                          w_state_nxt = DIV_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (r_state == DIV_BUSY);
    done = (r_state == DIV_DONE);
  end

  // Operand latch on start, then one shift-subtract step per BUSY cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (start && (r_state == DIV_IDLE)) begin
      r_cnt   <= '0;
      r_quot  <= w_abs_a;
      r_rem   <= '0;
      r_dvsr  <= w_abs_b;
      r_neg_q <= sgn & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      r_neg_r <= sgn & dividend[XLEN-1];
    end else if (r_state == DIV_BUSY) begin
      r_cnt <= r_cnt + 6'd1;
      if (!w_diff[XLEN]) begin
        r_rem  <= w_diff[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b1};
      end else begin
        r_rem  <= w_shift[XLEN-1:0];
        r_quot <= {r_quot[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = r_neg_q ? (~r_quot + 1'b1) : r_quot;
  assign remainder = r_neg_r ? (~r_rem + 1'b1)  : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX stage ALU with single-cycle multiply and an optional
//               iterative divider that stalls the pipeline while busy.
//               Macro EX_DIV_EN compiles the divider in; without it divide
//               ops return 0 and never stall.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = REG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALUOP_W-1:0]   aluop,
  input  logic [ALUSEL_W-1:0]  alusel,
  input  logic [XLEN-1:0]      opv1,
  input  logic [XLEN-1:0]      opv2,
  input  logic [REGADDR_W-1:0] reg_waddr_i,
  input  logic                 we_i,
  input  logic [5:0]           stall,
  output logic [XLEN-1:0]      wdata_o,
  output logic [REGADDR_W-1:0] reg_waddr_o,
  output logic                 we_o,
  output logic                 stall_req
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0]   w_shamt;
  logic [2*XLEN-1:0] w_a_s, w_b_s, w_a_u, w_b_u;
  logic [2*XLEN-1:0] w_prod_ss, w_prod_su, w_prod_uu;
  logic [XLEN-1:0]   w_logic_res, w_shift_res, w_arith_res, w_muldiv_res;
  logic [XLEN-1:0]   w_result;
  logic [XLEN-1:0]   w_div_res;
  logic              w_div_active;
  logic              w_stall_req;
  logic              w_is_div;

  assign w_shamt  = opv2[SH_W-1:0];
  assign w_is_div = is_div_op(aluop);

  // Full-width products; truncation of the sign-extended operands yields the
  // correct signed/mixed/unsigned high halves.
  assign w_a_s     = {{XLEN{opv1[XLEN-1]}}, opv1};
  assign w_b_s     = {{XLEN{opv2[XLEN-1]}}, opv2};
  assign w_a_u     = {{XLEN{1'b0}}, opv1};
  assign w_b_u     = {{XLEN{1'b0}}, opv2};
  assign w_prod_ss = w_a_s * w_b_s;
  assign w_prod_su = w_a_s * w_b_u;
  assign w_prod_uu = w_a_u * w_b_u;

  // Logic and shift class results
  always_comb begin
    w_logic_res = '0;
    w_shift_res = '0;
    case (aluop)
      EXE_AND_OP: w_logic_res = opv1 & opv2;
      EXE_OR_OP:  w_logic_res = opv1 | opv2;
      EXE_XOR_OP: w_logic_res = opv1 ^ opv2;
      EXE_SLL_OP: w_shift_res = opv1 << w_shamt;
      EXE_SRL_OP: w_shift_res = opv1 >> w_shamt;
      EXE_SRA_OP: w_shift_res = $signed(opv1) >>> w_shamt;
      default: ;
    endcase
  end

  // Arithmetic and mul/div class results
  always_comb begin
    w_arith_res  = '0;
    w_muldiv_res = '0;
    case (aluop)
      EXE_ADD_OP:    w_arith_res  = opv1 + opv2;
      EXE_SUB_OP:    w_arith_res  = opv1 - opv2;
      EXE_SLT_OP:    w_arith_res  = {{(XLEN-1){1'b0}}, ($signed(opv1) < $signed(opv2))};
      EXE_SLTU_OP:   w_arith_res  = {{(XLEN-1){1'b0}}, (opv1 < opv2)};
      EXE_MUL_OP:    w_muldiv_res = w_prod_ss[XLEN-1:0];
      EXE_MULH_OP:   w_muldiv_res = w_prod_ss[2*XLEN-1:XLEN];
      EXE_MULHSU_OP: w_muldiv_res = w_prod_su[2*XLEN-1:XLEN];
      EXE_MULHU_OP:  w_muldiv_res = w_prod_uu[2*XLEN-1:XLEN];
      default:       if (w_is_div) w_muldiv_res = w_div_res;
    endcase
  end

`ifdef EX_DIV_EN
  logic            w_div_signed, w_is_rem, w_div_zero, w_div_ovf;
  logic            w_div_start, w_div_busy, w_div_done, w_div_idle;
  logic [XLEN-1:0] w_div_q, w_div_r;
  logic            r_rem_sel;
  logic            w_unused;

  assign w_unused     = ^{stall[5:4], stall[2:0]};
  assign w_div_signed = (aluop == EXE_DIV_OP) || (aluop == EXE_REM_OP);
  assign w_is_rem     = (aluop == EXE_REM_OP) || (aluop == EXE_REMU_OP);
  assign w_div_zero   = (opv2 == '0);
  assign w_div_ovf    = w_div_signed && (opv1 == {1'b1, {(XLEN-1){1'b0}}}) && (opv2 == '1);
  assign w_div_idle   = !w_div_busy && !w_div_done;
  // Zero divisor and signed overflow are resolved in the issue cycle
  assign w_div_start  = w_div_idle && w_is_div && !w_div_zero && !w_div_ovf && !stall[3];
  assign w_div_active = w_div_busy || w_div_done;
  assign w_stall_req  = w_div_start || w_div_busy;

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .sgn       (w_div_signed),
    .hold      (stall[3]),
    .dividend  (opv1),
    .divisor   (opv2),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_div_q),
    .remainder (w_div_r)
  );

  // Remember whether the in-flight divide returns quotient or remainder
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_rem_sel <= 1'b0;
    else if (w_div_start) r_rem_sel <= w_is_rem;
  end

  // Divide result: latched divider output, or an issue-cycle special case
  always_comb begin
    w_div_res = '0;
    if (w_div_done)
      w_div_res = r_rem_sel ? w_div_r : w_div_q;
    else if (w_div_idle && w_is_div && w_div_zero)
      w_div_res = w_is_rem ? opv1 : '1;
    else if (w_div_idle && w_is_div && w_div_ovf)
      w_div_res = w_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  logic w_unused;

  assign w_unused     = ^{clk, stall};
  assign w_div_res    = '0;
  assign w_div_active = 1'b0;
  assign w_stall_req  = 1'b0;
`endif

  // Result-class select; an active divider owns the write-back value
  always_comb begin
    w_result = '0;
    case (alusel)
      EXE_RES_LOGIC:  w_result = w_logic_res;
      EXE_RES_SHIFT:  w_result = w_shift_res;
      EXE_RES_ARITH:  w_result = w_arith_res;
      EXE_RES_MULDIV: w_result = w_muldiv_res;
      default:        w_result = '0;
    endcase
    if (w_div_active) w_result = w_div_res;
  end

  // Outputs are forced quiet while reset is asserted
  assign wdata_o     = rst ? w_result : '0;
  assign we_o        = we_i & rst;
  assign stall_req   = w_stall_req & rst;
  assign reg_waddr_o = reg_waddr_i;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv; random ALU/mul traffic and
//               directed plus random divides against an arithmetic model.
//               Divide expectations follow the EX_DIV_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] opv1, opv2;
  logic [4:0]  reg_waddr_i;
  logic        we_i;
  logic [5:0]  stall;
  logic [31:0] wdata_o;
  logic [4:0]  reg_waddr_o;
  logic        we_o;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop       (aluop),
    .alusel      (alusel),
    .opv1        (opv1),
    .opv2        (opv2),
    .reg_waddr_i (reg_waddr_i),
    .we_i        (we_i),
    .stall       (stall),
    .wdata_o     (wdata_o),
    .reg_waddr_o (reg_waddr_o),
    .we_o        (we_o),
    .stall_req   (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: RV32IM-style semantics from plain arithmetic
  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, za, zb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    za = longint'({32'h0, a});
    zb = longint'({32'h0, b});
    r  = 32'h0;
    case (op)
      EXE_AND_OP:    r = a & b;
      EXE_OR_OP:     r = a | b;
      EXE_XOR_OP:    r = a ^ b;
      EXE_SLL_OP:    r = 32'(za << b[4:0]);
      EXE_SRL_OP:    r = 32'(za >> b[4:0]);
      EXE_SRA_OP:    r = 32'(sa >>> b[4:0]);
      EXE_ADD_OP:    r = 32'(za + zb);
      EXE_SUB_OP:    r = 32'(za - zb);
      EXE_SLT_OP:    r = (sa < sb) ? 32'd1 : 32'd0;
      EXE_SLTU_OP:   r = (za < zb) ? 32'd1 : 32'd0;
      EXE_MUL_OP:    begin p = 64'(sa * sb); r = p[31:0];  end
      EXE_MULH_OP:   begin p = 64'(sa * sb); r = p[63:32]; end
      EXE_MULHSU_OP: begin p = 64'(sa * zb); r = p[63:32]; end
      EXE_MULHU_OP:  begin p = 64'(za * zb); r = p[63:32]; end
`ifdef EX_DIV_EN
      EXE_DIV_OP:    r = (b == 0) ? 32'hFFFF_FFFF :
                         ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb));
      EXE_REM_OP:    r = (b == 0) ? a :
                         ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb));
      EXE_DIVU_OP:   r = (b == 0) ? 32'hFFFF_FFFF : 32'(za / zb);
      EXE_REMU_OP:   r = (b == 0) ? a : 32'(za % zb);
`endif
      default:       r = 32'h0;
    endcase
    return r;
  endfunction

  // Expected number of cycles with stall_req high for a divide issue
  function automatic int div_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 0;
`ifdef EX_DIV_EN
    if (b != 0 && !((op == EXE_DIV_OP || op == EXE_REM_OP) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
      lat = 33;
`endif
    return lat;
  endfunction

  function automatic logic [2:0] sel_of(input logic [7:0] op);
    case (op)
      EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP:                      return EXE_RES_LOGIC;
      EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:                     return EXE_RES_SHIFT;
      EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP:        return EXE_RES_ARITH;
      default:                                                return EXE_RES_MULDIV;
    endcase
  endfunction

  function automatic logic [7:0] rand_comb_op();
    case ($urandom_range(0, 13))
      0: return EXE_AND_OP;   1: return EXE_OR_OP;    2: return EXE_XOR_OP;
      3: return EXE_SLL_OP;   4: return EXE_SRL_OP;   5: return EXE_SRA_OP;
      6: return EXE_ADD_OP;   7: return EXE_SUB_OP;   8: return EXE_SLT_OP;
      9: return EXE_SLTU_OP; 10: return EXE_MUL_OP;  11: return EXE_MULH_OP;
      12: return EXE_MULHSU_OP;
      default: return EXE_MULHU_OP;
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  // One combinational operation, checked mid-cycle
  task automatic comb_op(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] wa;
    logic       we;
    wa = 5'($urandom);
    we = 1'($urandom);
    @(negedge clk);
    aluop = op; alusel = sel_of(op); opv1 = a; opv2 = b;
    reg_waddr_i = wa; we_i = we; stall = 6'h0;
    #1;
    chk(tag, wdata_o, model(op, a, b));
    chk({tag, "_ctl"}, {25'h0, stall_req, we_o, reg_waddr_o}, {25'h0, 1'b0, we, wa});
  endtask

  // Issue a divide, measure its stall window, hold DONE, then return to IDLE
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_v;
    logic [31:0] x, y;
    int          exp_l, n;
    exp_v = model(op, a, b);
    exp_l = div_lat(op, a, b);
    @(negedge clk);
    aluop = op; alusel = EXE_RES_MULDIV; opv1 = a; opv2 = b; stall = 6'h0; we_i = 1'b1;
    #1;
    n = 0;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      opv1 = $urandom; opv2 = $urandom; stall = 6'b001111;
      #1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_l));
    chk({tag, "_res"}, wdata_o, exp_v);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk({tag, "_hold"}, {wdata_o[31:1], wdata_o[0] ^ stall_req}, exp_v);
    end
    x = $urandom; y = $urandom;
    stall = 6'h0; aluop = EXE_ADD_OP; alusel = EXE_RES_ARITH; opv1 = x; opv2 = y;
    #1;
    if (exp_l != 0) chk({tag, "_pre_idle"}, wdata_o, exp_v);
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, wdata_o, x + y);
  endtask

  initial begin
    logic [7:0] op;
    rst = 1'b0; aluop = EXE_DIV_OP; alusel = EXE_RES_MULDIV;
    opv1 = 32'd20; opv2 = 32'd3; reg_waddr_i = 5'd9; we_i = 1'b1; stall = 6'h0;
    #12;
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    chk("rst_we", {31'h0, we_o}, 32'h0);
    chk("rst_waddr", {27'h0, reg_waddr_o}, 32'd9);
    @(negedge clk);
    aluop = EXE_NOP_OP; rst = 1'b1;

    comb_op("add_5_7", EXE_ADD_OP, 32'd5, 32'd7);
    chk("add_5_7_const", wdata_o, 32'd12);
    comb_op("mulhu_max", EXE_MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhu_max_const", wdata_o, 32'hFFFF_FFFE);
    comb_op("mulh_neg", EXE_MULH_OP, 32'h8000_0000, 32'h8000_0000);
    comb_op("mulhsu_neg", EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int k = 0; k < 300; k++) comb_op("rand_comb", rand_comb_op(), rand_val(), rand_val());

    comb_op("unknown_arith", 8'hEE, $urandom, $urandom);
    @(negedge clk);
    alusel = EXE_RES_MULDIV;
    #1;
    chk("unknown_muldiv", wdata_o, 32'h0);

    run_div("div_m20_3", EXE_DIV_OP, 32'hFFFF_FFEC, 32'd3, 0);
    run_div("rem_m20_3", EXE_REM_OP, 32'hFFFF_FFEC, 32'd3, 4);
    run_div("divu_by0", EXE_DIVU_OP, 32'd7, 32'd0, 0);
    run_div("remu_by0", EXE_REMU_OP, 32'd7, 32'd0, 0);
    run_div("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("rem_ovf", EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("divu_big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 1);
    run_div("rem_minint", EXE_REM_OP, 32'h8000_0000, 32'd7, 0);

    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: op = EXE_DIV_OP;
        1: op = EXE_DIVU_OP;
        2: op = EXE_REM_OP;
        default: op = EXE_REMU_OP;
      endcase
      run_div("rand_div", op, rand_val(), (k % 5 == 0) ? 32'h0 : $urandom_range(1, 1000) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h1), $urandom_range(0, 3));
    end

    // Reset in the middle of a divide
    @(negedge clk);
    aluop = EXE_DIV_OP; alusel = EXE_RES_MULDIV; opv1 = 32'd1000; opv2 = 32'd3; stall = 6'h0; we_i = 1'b1;
    #1;
    chk("mid_issue_stall", {31'h0, stall_req}, (div_lat(EXE_DIV_OP, 32'd1000, 32'd3) != 0) ? 32'd1 : 32'd0);
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'h0, stall_req}, 32'h0);
    chk("mid_rst_wdata", wdata_o, 32'h0);
    chk("mid_rst_we", {31'h0, we_o}, 32'h0);
    @(negedge clk);
    aluop = EXE_NOP_OP; rst = 1'b1;
    run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 0);
    chk("divu_100_7_model", model(EXE_DIVU_OP, 32'd100, 32'd7), div_lat(EXE_DIVU_OP, 32'd100, 32'd7) != 0 ? 32'd14 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
